// File: rtl/uart_tx_arbiter.sv
//============================================================================
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ
// byte sources. Optional busy-handshake timeout via UART_ARB_TIMEOUT_EN.
// Revision: 1.0
//============================================================================
`default_nettype none

module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [8*N_REQ-1:0]         req_data,
   output logic [N_REQ-1:0]           grant,
   output logic [7:0]                 tx_data,
   output logic                       tx_send,
   input  logic                       tx_busy,
   output logic [$clog2(N_REQ)-1:0]   active_id,
   output logic                       tx_timeout
);

   localparam int ID_W = $clog2(N_REQ);

   generate
      if (N_REQ < 2 || N_REQ > 8 || BUSY_TIMEOUT < 1) begin : g_param_check
         $error("uart_tx_arbiter: illegal parameter value");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              w_found;
   logic [ID_W-1:0]   w_winner;
   logic [ID_W:0]     w_sum;
   logic [ID_W-1:0]   w_cand;
   logic              w_send;
   logic [N_REQ-1:0]  w_grant;
   logic [7:0]        w_tx_data;
   logic [ID_W-1:0]   w_active_id;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
   logic [CNT_W-1:0]  r_cnt;
   logic              w_timeout;
`endif

   // Search starts one past the last winner and wraps; the one-bit-wider
   // sum keeps the modulo a single conditional subtract.
   always_comb begin : p_rr_search
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      w_cand   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sum = {1'b0, active_id} + (ID_W+1)'(k + 1);
         if (w_sum >= (ID_W+1)'(N_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(N_REQ);
         end
         w_cand = w_sum[ID_W-1:0];
         if (!w_found && req[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   always_comb begin : p_fsm
      w_next_state = r_state;
      w_send       = 1'b0;
      w_grant      = '0;
      w_tx_data    = tx_data;
      w_active_id  = active_id;
`ifdef UART_ARB_TIMEOUT_EN
      w_timeout    = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (!tx_busy && w_found) begin
               w_next_state = WAIT_BUSY;
               w_send       = 1'b1;
               w_active_id  = w_winner;
               for (int i = 0; i < N_REQ; i++) begin
                  w_grant[i] = (w_winner == ID_W'(i));
                  if (w_winner == ID_W'(i)) begin
                     w_tx_data = req_data[8*i +: 8];
                  end
               end
            end
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               w_next_state = WAIT_DONE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            // Fires on the edge at which the count reaches BUSY_TIMEOUT.
            else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
               w_next_state = IDLE;
               w_timeout    = 1'b1;
            end
`endif
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin : p_regs
      if (rst) begin
         r_state   <= IDLE;
         tx_send   <= 1'b0;
         grant     <= '0;
         tx_data   <= 8'h00;
         active_id <= ID_W'(N_REQ - 1);
      end else begin
         r_state   <= w_next_state;
         tx_send   <= w_send;
         grant     <= w_grant;
         tx_data   <= w_tx_data;
         active_id <= w_active_id;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin : p_timeout
      if (rst) begin
         r_cnt      <= '0;
         tx_timeout <= 1'b0;
      end else begin
         tx_timeout <= w_timeout;
         if (r_state != WAIT_BUSY) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
`else
   assign tx_timeout = 1'b0;
`endif

endmodule

`default_nettype wire
